// File: rtl/battle_datapath.sv
// battle_datapath
//   Datapath side of the battle controller. Follows the one-hot state strobes
//   coming from the battle FSM, keeps both HP counters, the selected player and
//   AI moves and the pending damage, and rolls hit/miss from a free-running
//   8-bit LFSR. hp_is_zero feeds the FSM; the HP/move/damage outputs feed the
//   HEX/LED display.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   player_move  player move index from the switches
//   ld_pm, calc_ph, apply_ad, ld_am, calc_ah, apply_pd
//                FSM state strobes (high for the whole dwell in that state)
//   victory, loss
//                FSM end-state strobes; freeze the datapath
//   roll_ovr_en  use roll_ovr instead of the LFSR for rolls and the AI move
//   roll_ovr     forced roll value
//   player_hp    player HP
//   ai_hp        AI HP
//   ai_move      AI move latched on LOAD_AM entry
//   dmg          damage produced by the most recent calc
//   last_hit     1 when the most recent calc hit
//   hp_is_zero   target HP of the current apply state is 0 (combinational)
//   strobe_err   sticky flag: more than one strobe seen high in a cycle
module battle_datapath #(
  parameter int          HP_W      = 4,
  parameter int unsigned MAX_HP    = 15,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      player_move,
  input  logic            ld_pm,
  input  logic            calc_ph,
  input  logic            apply_ad,
  input  logic            ld_am,
  input  logic            calc_ah,
  input  logic            apply_pd,
  input  logic            victory,
  input  logic            loss,
  input  logic            roll_ovr_en,
  input  logic [7:0]      roll_ovr,
  output logic [HP_W-1:0] player_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic [1:0]      ai_move,
  output logic [3:0]      dmg,
  output logic            last_hit,
  output logic            hp_is_zero,
  output logic            strobe_err
);

  // Bit positions inside the action-strobe vector.
  localparam int I_LD_PM    = 5;
  localparam int I_CALC_PH  = 4;
  localparam int I_APPLY_AD = 3;
  localparam int I_LD_AM    = 2;
  localparam int I_CALC_AH  = 1;
  localparam int I_APPLY_PD = 0;

  // Damage of each move.
  function automatic logic [3:0] move_pow(input logic [1:0] mv);
    logic [3:0] p;
    case (mv)
      2'd0:    p = 4'd2;
      2'd1:    p = 4'd3;
      2'd2:    p = 4'd4;
      default: p = 4'd6;
    endcase
    return p;
  endfunction

  // Hit test: roll below the move's threshold. Move 0 has threshold 256, so
  // every 8-bit roll hits.
  function automatic logic move_hits(input logic [1:0] mv, input logic [7:0] r);
    logic h;
    case (mv)
      2'd0:    h = 1'b1;
      2'd1:    h = (r < 8'd192);
      2'd2:    h = (r < 8'd128);
      default: h = (r < 8'd64);
    endcase
    return h;
  endfunction

  // HP minus damage, clamped at zero. One extra bit holds the sign of the
  // difference so a borrow is detected instead of wrapping.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                              input logic [3:0]      d);
    logic signed [HP_W:0] diff;
    diff = $signed({1'b0, hp}) - $signed({1'b0, HP_W'(d)});
    return diff[HP_W] ? '0 : diff[HP_W-1:0];
  endfunction

  logic [7:0] lfsr;
  logic [7:0] roll;
  logic [1:0] pm_reg;
  logic [5:0] act_vec;
  logic [5:0] act_q;
  logic [5:0] entry;
  logic       multi;
  logic       act_ok;
  logic [1:0] calc_move;
  logic       calc_hit;

  assign act_vec = {ld_pm, calc_ph, apply_ad, ld_am, calc_ah, apply_pd};

  // The FSM dwells in a state until go, so actions key off the rising edge
  // of each strobe rather than its level.
  assign entry  = act_vec & ~act_q;
  assign multi  = ($countones({act_vec, victory, loss}) > 1);
  assign act_ok = ~multi & ~victory & ~loss;
  assign roll   = roll_ovr_en ? roll_ovr : lfsr;

  // calc_ph and calc_ah never overlap legally; pick whichever is active.
  assign calc_move = calc_ph ? pm_reg : ai_move;
  assign calc_hit  = move_hits(calc_move, roll);

  assign hp_is_zero = (apply_ad & (ai_hp == '0)) | (apply_pd & (player_hp == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr       <= LFSR_SEED;
      act_q      <= '0;
      pm_reg     <= '0;
      ai_move    <= '0;
      dmg        <= '0;
      last_hit   <= 1'b0;
      strobe_err <= 1'b0;
      player_hp  <= HP_W'(MAX_HP);
      ai_hp      <= HP_W'(MAX_HP);
    end else begin
      // LFSR and strobe history keep running even when frozen or in error.
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      act_q <= act_vec;
      if (multi) begin
        strobe_err <= 1'b1;
      end
      if (act_ok) begin
        if (ld_pm) begin
          pm_reg <= player_move;
        end
        if (entry[I_LD_AM]) begin
          ai_move <= roll[1:0];
        end
        if (entry[I_CALC_PH] | entry[I_CALC_AH]) begin
          dmg      <= calc_hit ? move_pow(calc_move) : 4'd0;
          last_hit <= calc_hit;
        end
        if (entry[I_APPLY_AD]) begin
          ai_hp <= sat_sub(ai_hp, dmg);
        end
        if (entry[I_APPLY_PD]) begin
          player_hp <= sat_sub(player_hp, dmg);
        end
      end
    end
  end

  // ld_pm is level-sensitive, so only its own level is consumed; its entry
  // bit exists just to keep the strobe vector uniform.
  logic unused_entry;
  assign unused_entry = entry[I_LD_PM];

endmodule
